// File: rtl/shr_univ.sv
// rtl/shr_univ.sv - universal shift register with shift/rotate ops and serial SEND frames
module shr_univ #(
    parameter int              WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit              MSB_FIRST = 1'b1,
    localparam int             AW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             r_n,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    amt,
    input  logic             si,
    input  logic [WIDTH-1:0] pi,
    output logic             so,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_SAR  = 3'b100,
        OP_ROL  = 3'b101,
        OP_ROR  = 3'b110,
        OP_SEND = 3'b111
    } op_e;

    localparam logic [WIDTH-1:0] ONES  = '1;
    localparam logic [AW:0]      W_EXT = (AW+1)'(WIDTH);

    logic [WIDTH-1:0] r_q;
    logic             r_busy;
    logic             r_done;
    logic [AW-1:0]    r_cnt;

    logic [AW-1:0]    w_rot_amt;
    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_sar;
    logic [WIDTH-1:0] w_rol;
    logic [WIDTH-1:0] w_ror;
    logic [WIDTH-1:0] w_ser;

    // amt < 2*WIDTH always holds, so one conditional subtract is a full modulo
    always_comb begin
        w_rot_amt = amt;
        if ({1'b0, amt} >= W_EXT) begin
            w_rot_amt = amt - W_EXT[AW-1:0];
        end
    end

    assign w_shl = (r_q << amt) | (~(ONES << amt) & {WIDTH{si}});
    assign w_shr = (r_q >> amt) | (~(ONES >> amt) & {WIDTH{si}});
    assign w_sar = (r_q >> amt) | (~(ONES >> amt) & {WIDTH{r_q[WIDTH-1]}});
    assign w_rol = (r_q << w_rot_amt) | (r_q >> (W_EXT - {1'b0, w_rot_amt}));
    assign w_ror = (r_q >> w_rot_amt) | (r_q << (W_EXT - {1'b0, w_rot_amt}));
    assign w_ser = MSB_FIRST ? {r_q[WIDTH-2:0], si} : {si, r_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!r_n) begin
            r_q    <= RESET_VAL;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_done <= 1'b0;
            if (en) begin
                if (r_busy) begin
                    r_q <= w_ser;
                    if (r_cnt == '0) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - AW'(1);
                    end
                end else begin
                    case (op_e'(op))
                        OP_HOLD: r_q <= r_q;
                        OP_LOAD: r_q <= pi;
                        OP_SHL:  r_q <= w_shl;
                        OP_SHR:  r_q <= w_shr;
                        OP_SAR:  r_q <= w_sar;
                        OP_ROL:  r_q <= w_rol;
                        OP_ROR:  r_q <= w_ror;
                        OP_SEND: begin
                            r_q    <= pi;
                            r_busy <= 1'b1;
                            r_cnt  <= AW'(WIDTH - 1);
                        end
                        default: r_q <= r_q;
                    endcase
                end
            end
        end
    end

    assign q    = r_q;
    assign busy = r_busy;
    assign done = r_done;
    assign so   = MSB_FIRST ? r_q[WIDTH-1] : r_q[0];

endmodule

// File: doc/shr_univ.md
Name: shr_univ

Overview:
- Parametrised universal shift register; the successor to the fixed 32-bit serial/parallel shift registers.
- Adds configurable width, a multi-bit shift amount, logical/arithmetic/rotate modes and both directions.
- Adds an autonomous serial-transmit (SEND) mode with busy/done status.
- Used as the general datapath shifter and bit-serial transmitter in the core.

Parameters:
WIDTH, 32, register width in bits (>=2)
RESET_VAL, 0, value loaded into q on reset (WIDTH bits)
MSB_FIRST, 1, 1: SEND shifts left and so taps q[WIDTH-1]; 0: SEND shifts right and so taps q[0]

Ports:
clk  input  1  clock; all state updates on rising edge
r_n  input  1  synchronous active-low reset
en  input  1  clock enable; 0 freezes q, busy and cnt
op  input  3  operation select (see Behaviour); ignored while busy
amt  input  AW=$clog2(WIDTH)  shift/rotate amount for ops 010-110
si  input  1  serial fill bit
pi  input  WIDTH  parallel load data
so  output  1  serial out = MSB_FIRST ? q[WIDTH-1] : q[0] (combinational from q)
q  output  WIDTH  register contents
busy  output  1  SEND frame in progress
done  output  1  one-cycle pulse at SEND completion

Behaviour:
- Reset: r_n=0 at an edge -> q=RESET_VAL, busy=0, done=0, cnt=0.
  - Overrides en, op and any frame in progress; an aborted frame produces no done.
- done is cleared at every edge where it is not being set, regardless of en.
- en=0, not reset: q, busy and cnt hold; done still clears.
- en=1, busy=0: op decoded at the edge.
  - 000 HOLD: no change.
  - 001 LOAD: q<=pi.
  - 010 SHL: q<=q<<amt; vacated low bits all = si.
  - 011 SHR: q<=q>>amt; vacated high bits all = si.
  - 100 SAR: q<=q>>amt; vacated high bits = old q[WIDTH-1].
  - 101 ROL: rotate left by amt.
  - 110 ROR: rotate right by amt.
  - 111 SEND: q<=pi, busy<=1, cnt<=WIDTH-1.
- amt=0 on ops 010-110: q unchanged. Max amt is WIDTH-1 (AW bits); no overflow case for power-of-two WIDTH.
- For non-power-of-two WIDTH, amt>=WIDTH behaves as:
  - SHL/SHR: all fill.
  - SAR: all sign.
  - ROL/ROR: amt mod WIDTH.
- Single-cycle latency: the result is visible on q the cycle after the edge.
- SEND frame:
  - After the load edge, so presents frame bit 0 (pi MSB if MSB_FIRST, else pi LSB).
  - Each en=1 edge with busy=1 shifts by exactly 1 in the MSB_FIRST direction, filling with si, then:
    - cnt!=0: cnt<=cnt-1.
    - cnt==0: busy<=0 and done<=1 at that edge.
  - busy is high for exactly WIDTH enabled cycles; so walks through all WIDTH bits in order, one per enabled cycle.
  - After the frame, q = pi shifted WIDTH times = all bits taken from si over the frame.
  - en=0 mid-frame stalls so, q and cnt; the bit period is stretched, with no bit lost or repeated.
  - op is ignored while busy, including LOAD, SEND and shifts.
  - A new SEND is accepted on the edge after busy falls (the cycle done=1), giving back-to-back frames with one idle cycle.
- State: q[WIDTH], busy, done, cnt[AW]. No other storage.

Test Plan:
- WIDTH=8, RESET_VAL=8'hA5: hold r_n=0 for 2 edges with en=1, op=001, pi=8'hFF -> q=8'hA5, busy=0, done=0. Release r_n -> LOAD gives q=8'hFF next cycle.
- WIDTH=8: LOAD 8'h96, then:
  - SHL amt=3, si=1 -> q=8'hB7.
  - SAR amt=2 -> q=8'hED.
  - ROR amt=4 -> q=8'hDE.
  - ROL amt=0 -> q=8'hDE.
  - SHR amt=7, si=0 -> q=8'h01.
- WIDTH=8, MSB_FIRST=1: SEND pi=8'hC3, si=0, en=1 -> so sequence 1,1,0,0,0,0,1,1 over 8 cycles with busy=1. done=1 for exactly one cycle after the 8th bit; q=8'h00; busy=0.
- Same SEND with en=0 for 3 cycles after bit 2 and op=001 pulsed mid-frame -> so holds bit 2 for 4 cycles; LOAD ignored; bit sequence unchanged; done after 8 enabled busy cycles.
- SEND 8'hFF, then assert r_n=0 at bit 4 -> next cycle q=RESET_VAL, busy=0; done never asserts.
- WIDTH=32, MSB_FIRST=0: SEND 32'h55555555 -> so alternates 1,0,1,0... for 32 cycles. Back-to-back SEND issued in the done cycle -> busy re-asserts next cycle.
